// File: rtl/hydra_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package  : hydra_mem_pkg
// Brief    : shared constants, id-width helper and FSM encoding for the
//            multi-core memory arbiter
// Revision : 1.0
// ============================================================================
package hydra_mem_pkg;

   localparam int         N_CORES_DEFAULT = 4;
   localparam logic [3:0] WSTRB_READ      = 4'b0000;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_t;

   // Core-id width never collapses to zero, even for two cores.
   function automatic int cid_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : mem_arbiter_if
// Brief     : picorv32-style native target bus between arbiter and decode
// Revision  : 1.0
// ============================================================================
interface mem_arbiter_if;

   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport master (
      output mem_valid, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata
   );

endinterface
`default_nettype wire

// File: rtl/mem_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : mem_rr_pick
// Brief    : combinational round-robin pick, first eligible after last_grant
// Revision : 1.0
// ============================================================================
module mem_rr_pick #(
   parameter int N_CORES = 4,
   parameter int CID_W   = 2
) (
   input  wire [N_CORES-1:0] elig,
   input  wire [CID_W-1:0]   last_grant,
   output logic              any,
   output logic [CID_W-1:0]  winner
);

   int w_dist;
   int w_best;

   // Rank each core by its rotational distance past last_grant; nearest wins.
   always_comb begin
      any    = 1'b0;
      winner = '0;
      w_dist = 0;
      w_best = N_CORES;
      for (int i = 0; i < N_CORES; i++) begin
         w_dist = (i - int'(last_grant) - 1 + 2 * N_CORES) % N_CORES;
         if (elig[i] && (w_dist < w_best)) begin
            w_best = w_dist;
            winner = CID_W'(i);
            any    = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : round-robin arbiter sharing one target port between picorv32
//            masters, one transaction in flight, timeout-forced completion
// Revision : 1.0
// ============================================================================
module mem_arbiter
   import hydra_mem_pkg::*;
#(
   parameter int N_CORES = N_CORES_DEFAULT,
   parameter int CID_W   = cid_width(N_CORES),
   parameter int TIMEOUT = 255
) (
   input  wire                      clk,
   input  wire                      resetn,
   input  wire  [N_CORES-1:0]       core_valid,
   input  wire  [32*N_CORES-1:0]    core_addr,
   input  wire  [32*N_CORES-1:0]    core_wdata,
   input  wire  [4*N_CORES-1:0]     core_wstrb,
   output logic [N_CORES-1:0]       core_ready,
   output logic [32*N_CORES-1:0]    core_rdata,
   mem_arbiter_if.master            mem,
   output logic [CID_W-1:0]         grant_id,
   output logic                     bus_err
);

   localparam logic [7:0] c_timer_last = 8'(TIMEOUT - 1);

   arb_state_t              r_state;
   logic [CID_W-1:0]        r_last_grant;
   logic [CID_W-1:0]        r_grant_id;
   logic [7:0]              r_timer;
   logic                    r_mem_valid;
   logic [31:0]             r_mem_addr;
   logic [31:0]             r_mem_wdata;
   logic [3:0]              r_mem_wstrb;
   logic [N_CORES-1:0]      r_core_ready;
   logic [32*N_CORES-1:0]   r_core_rdata;
   logic                    r_bus_err;

   logic [N_CORES-1:0]      w_elig;
   logic                    w_any;
   logic [CID_W-1:0]        w_winner;
   logic [31:0]             w_sel_addr;
   logic [31:0]             w_sel_wdata;
   logic [3:0]              w_sel_wstrb;
   logic                    w_done;

   // A core whose ready pulse is out this cycle still shows valid; mask it.
   assign w_elig = core_valid & ~r_core_ready;
   assign w_done = mem.mem_ready | (r_timer == c_timer_last);

   mem_rr_pick #(
      .N_CORES    (N_CORES),
      .CID_W      (CID_W)
   ) u_pick (
      .elig       (w_elig),
      .last_grant (r_last_grant),
      .any        (w_any),
      .winner     (w_winner)
   );

   always_comb begin
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      w_sel_wstrb = '0;
      for (int i = 0; i < N_CORES; i++) begin
         if (w_winner == CID_W'(i)) begin
            w_sel_addr  = core_addr[32*i +: 32];
            w_sel_wdata = core_wdata[32*i +: 32];
            w_sel_wstrb = core_wstrb[4*i +: 4];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= ST_IDLE;
         r_last_grant <= CID_W'(N_CORES - 1);
         r_grant_id   <= '0;
         r_timer      <= '0;
         r_mem_valid  <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_mem_wstrb  <= '0;
         r_core_ready <= '0;
         r_core_rdata <= '0;
         r_bus_err    <= 1'b0;
      end else begin
         r_core_ready <= '0;
         r_bus_err    <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_mem_valid <= 1'b1;
                  r_mem_addr  <= w_sel_addr;
                  r_mem_wdata <= w_sel_wdata;
                  r_mem_wstrb <= w_sel_wstrb;
                  r_grant_id  <= w_winner;
                  r_timer     <= '0;
                  r_state     <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (r_timer < c_timer_last) begin
                  r_timer <= r_timer + 8'd1;
               end
               if (w_done) begin
                  r_mem_valid  <= 1'b0;
                  r_bus_err    <= ~mem.mem_ready;
                  r_last_grant <= r_grant_id;
                  r_state      <= ST_IDLE;
                  for (int i = 0; i < N_CORES; i++) begin
                     if (r_grant_id == CID_W'(i)) begin
                        r_core_ready[i]          <= 1'b1;
                        r_core_rdata[32*i +: 32] <= mem.mem_ready ? mem.mem_rdata : 32'h0;
                     end
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign mem.mem_valid = r_mem_valid;
   assign mem.mem_addr  = r_mem_addr;
   assign mem.mem_wdata = r_mem_wdata;
   assign mem.mem_wstrb = r_mem_wstrb;
   assign core_ready    = r_core_ready;
   assign core_rdata    = r_core_rdata;
   assign grant_id      = r_grant_id;
   assign bus_err       = r_bus_err;

endmodule
`default_nettype wire
